// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder and loader.
// Accepts symbolic instructions over a valid/ready stream, encodes each one
// into a 32-bit MIPS word and writes it to instruction memory through a
// req/ack port at consecutive word addresses starting at BASE_ADDR.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               one-cycle pulse, begins a session (IDLE / ERR only)
//   in_valid/in_ready   instruction stream handshake
//   in_op..in_last      symbolic instruction fields
//   imem_req/imem_ack   write handshake; imem_addr/imem_wdata held until ack
//   busy, done, err     session status (done is a one-cycle pulse)
//   err_code            0 none, 1 illegal op, 2 address overflow
//   count               words written in the current/last session
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVFL    = 2'd2;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [2:0]        state, state_nxt;
    logic              last_q, last_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [1:0]        err_code_nxt;

    logic [31:0]       enc_word;
    logic              enc_illegal;

    // Encode the presented instruction into a MIPS word.
    always_comb begin
        enc_word    = 32'd0;
        enc_illegal = 1'b0;
        case (in_op)
            4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            4'd2:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            4'd3:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            4'd4:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            4'd5:    enc_word = {6'h08, in_rs, in_rt, in_imm};
            4'd6:    enc_word = {6'h0D, in_rs, in_rt, in_imm};
            4'd7:    enc_word = {6'h0C, in_rs, in_rt, in_imm};
            4'd8:    enc_word = {6'h0A, in_rs, in_rt, in_imm};
            4'd9:    enc_word = {6'h23, in_rs, in_rt, in_imm};
            4'd10:   enc_word = {6'h2B, in_rs, in_rt, in_imm};
            4'd11:   enc_word = {6'h04, in_rs, in_rt, in_imm};
            4'd12:   enc_word = {6'h05, in_rs, in_rt, in_imm};
            4'd13:   enc_word = {6'h02, in_target};
            default: enc_illegal = 1'b1;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last_q;
        addr_nxt     = imem_addr;
        wdata_nxt    = imem_wdata;
        count_nxt    = count;
        err_code_nxt = err_code;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    addr_nxt     = BASE;
                    count_nxt    = '0;
                    err_code_nxt = ERR_NONE;
                    state_nxt    = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (enc_illegal) begin
                        err_code_nxt = ERR_ILLEGAL;
                        state_nxt    = S_ERR;
                    end else begin
                        wdata_nxt = enc_word;
                        last_nxt  = in_last;
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (imem_ack) begin
                    count_nxt = count + CNT_W'(1);
                    addr_nxt  = imem_addr + ADDR_W'(1);
                    if (last_q) begin
                        state_nxt = S_DONE;
                    end else if (&imem_addr) begin
                        // Next address would wrap onto already-written words.
                        err_code_nxt = ERR_OVFL;
                        state_nxt    = S_ERR;
                    end else begin
                        state_nxt = S_ACCEPT;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and status flags; flags track the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_q     <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
            count      <= '0;
            err_code   <= ERR_NONE;
            in_ready   <= 1'b0;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_q     <= last_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            count      <= count_nxt;
            err_code   <= err_code_nxt;
            in_ready   <= (state_nxt == S_ACCEPT);
            imem_req   <= (state_nxt == S_WRITE);
            busy       <= (state_nxt == S_ACCEPT) || (state_nxt == S_WRITE);
            done       <= (state_nxt == S_DONE);
            err        <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encoding stream,
// ack stalls, illegal op, reset mid-write, start during ACCEPT, a random
// stream, and address overflow on a 2-bit-address instance.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, in_last, imem_ack;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        r8, q8, b8, d8, e8;
    logic [7:0]  a8;
    logic [31:0] w8;
    logic [1:0]  c8e;
    logic [8:0]  n8;

    logic        r2, q2, b2, d2, e2;
    logic [1:0]  a2;
    logic [31:0] w2;
    logic [1:0]  c2e;
    logic [2:0]  n2;

    bit          sel;
    int          vectors = 0;
    int          miscompares = 0;
    int          exp_addr;
    int          exp_count;
    int          mask;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r8),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_req(q8), .imem_ack(imem_ack),
        .imem_addr(a8), .imem_wdata(w8), .busy(b8), .done(d8), .err(e8),
        .err_code(c8e), .count(n8)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(r2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_req(q2), .imem_ack(imem_ack),
        .imem_addr(a2), .imem_wdata(w2), .busy(b2), .done(d2), .err(e2),
        .err_code(c2e), .count(n2)
    );

    // Outputs of whichever instance is under observation.
    wire        o_ready = sel ? r2 : r8;
    wire        o_req   = sel ? q2 : q8;
    wire        o_busy  = sel ? b2 : b8;
    wire        o_done  = sel ? d2 : d8;
    wire        o_err   = sel ? e2 : e8;
    wire [1:0]  o_code  = sel ? c2e : c8e;
    wire [7:0]  o_addr  = sel ? {6'd0, a2} : a8;
    wire [31:0] o_wdata = sel ? w2 : w8;
    wire [8:0]  o_count = sel ? {6'd0, n2} : n8;

    // Reference encoding from the opcode/funct tables.
    function automatic logic [31:0] encode(input int op, input int rs, input int rt,
                                           input int rd, input int imm, input int tgt);
        int funct_tab [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int opc_tab   [8] = '{32'h08, 32'h0D, 32'h0C, 32'h0A, 32'h23, 32'h2B, 32'h04, 32'h05};
        longint w;
        if (op <= 4)
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + funct_tab[op];
        else if (op <= 12)
            w = longint'(opc_tab[op-5]) * 67108864 + longint'(rs) * 2097152
                + longint'(rt) * 65536 + longint'(imm);
        else
            w = 2 * 67108864 + longint'(tgt);
        return 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr  = 0;
        exp_count = 0;
        chk("start_ready", 32'(o_ready), 1);
        chk("start_err", 32'(o_err), 0);
        chk("start_code", 32'(o_code), 0);
    endtask

    task automatic present(input int op, input int rs, input int rt, input int rd,
                           input int imm, input int tgt, input bit last);
        int n;
        in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // One instruction through accept, optional ack stall, and write.
    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm,
                        input int tgt, input bit last, input int dly, input logic [31:0] expw);
        present(op, rs, rt, rd, imm, tgt, last);
        chk("req", 32'(o_req), 1);
        chk("addr", 32'(o_addr), 32'(exp_addr));
        chk("wdata", o_wdata, expw);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("stall_req", 32'(o_req), 1);
            chk("stall_ready", 32'(o_ready), 0);
            chk("stall_addr", 32'(o_addr), 32'(exp_addr));
            chk("stall_wdata", o_wdata, expw);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        exp_count++;
        chk("count", 32'(o_count), 32'(exp_count));
        chk("req_drop", 32'(o_req), 0);
        if (last) begin
            chk("done", 32'(o_done), 1);
            chk("done_err", 32'(o_err), 0);
        end else if (exp_addr == mask) begin
            chk("ovfl_err", 32'(o_err), 1);
            chk("ovfl_code", 32'(o_code), 2);
        end else begin
            chk("next_ready", 32'(o_ready), 1);
        end
        exp_addr = (exp_addr + 1) & mask;
    endtask

    initial begin
        int op, rs, rt, rd, imm, tgt, dly;
        sel = 1'b0; mask = 255;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ack = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        #12;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_req", 32'(o_req), 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_code", 32'(o_code), 0);
        chk("rst_count", 32'(o_count), 0);
        rst_n = 1'b1;
        tick();

        // Directed encoding stream, ack stalled 3 cycles on the second word.
        do_start();
        send(0, 1, 2, 3, 0, 0, 1'b0, 0, 32'h00221820);
        send(5, 0, 1, 31, 5, 0, 1'b0, 3, 32'h20010005);
        send(9, 0, 2, 0, 4, 0, 1'b0, 0, 32'h8C020004);
        send(10, 0, 2, 0, 8, 0, 1'b0, 0, 32'hAC020008);
        send(11, 1, 2, 0, 16'hFFFF, 0, 1'b0, 0, 32'h1022FFFF);
        send(13, 7, 7, 7, 16'h1234, 32'h10, 1'b1, 0, 32'h08000010);
        tick();
        chk("done_pulse", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("count_hold", 32'(o_count), 6);

        // Illegal op as the third instruction.
        do_start();
        send(1, 4, 5, 6, 0, 0, 1'b0, 0, encode(1, 4, 5, 6, 0, 0));
        send(6, 3, 9, 0, 16'hA5A5, 0, 1'b0, 1, encode(6, 3, 9, 0, 16'hA5A5, 0));
        present(14, 1, 1, 1, 1, 1, 1'b0);
        chk("ill_err", 32'(o_err), 1);
        chk("ill_code", 32'(o_code), 1);
        chk("ill_count", 32'(o_count), 2);
        chk("ill_req", 32'(o_req), 0);
        in_valid = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_no_req", 32'(o_req), 0);
            chk("err_hold_count", 32'(o_count), 2);
            chk("err_hold_code", 32'(o_code), 1);
        end
        in_valid = 1'b0; imem_ack = 1'b0;
        do_start();
        send(2, 8, 9, 10, 0, 0, 1'b0, 0, encode(2, 8, 9, 10, 0, 0));

        // Start during ACCEPT is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("acc_start_addr", 32'(o_addr), 1);
        chk("acc_start_count", 32'(o_count), 1);
        chk("acc_start_busy", 32'(o_busy), 1);
        send(3, 1, 1, 1, 0, 0, 1'b1, 2, encode(3, 1, 1, 1, 0, 0));
        tick();

        // Reset asserted mid-WRITE.
        do_start();
        present(4, 2, 3, 4, 0, 0, 1'b0);
        chk("pre_rst_req", 32'(o_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(o_req), 0);
        chk("mid_rst_addr", 32'(o_addr), 0);
        chk("mid_rst_wdata", o_wdata, 0);
        chk("mid_rst_busy", 32'(o_busy), 0);
        start = 1'b1; in_valid = 1'b1; imem_ack = 1'b1;
        tick();
        tick();
        chk("in_rst_req", 32'(o_req), 0);
        chk("in_rst_ready", 32'(o_ready), 0);
        chk("in_rst_count", 32'(o_count), 0);
        start = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("post_rst_req", 32'(o_req), 0);

        // Random stream with random ack stalls.
        do_start();
        for (int k = 0; k < 24; k++) begin
            op  = int'($urandom_range(0, 13));
            rs  = int'($urandom_range(0, 31));
            rt  = int'($urandom_range(0, 31));
            rd  = int'($urandom_range(0, 31));
            imm = int'($urandom_range(0, 65535));
            tgt = int'($urandom & 32'h03FF_FFFF);
            dly = int'($urandom_range(0, 3));
            send(op, rs, rt, rd, imm, tgt, k == 23, dly, encode(op, rs, rt, rd, imm, tgt));
        end
        tick();

        // Address overflow on the 2-bit instance.
        sel = 1'b1; mask = 3;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        for (int k = 0; k < 4; k++)
            send(5, k, k + 1, 0, k, 0, 1'b0, k & 1, encode(5, k, k + 1, 0, k, 0));
        chk("ovfl_count", 32'(o_count), 4);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovfl_no_req", 32'(o_req), 0);
            chk("ovfl_no_ready", 32'(o_ready), 0);
        end
        in_valid = 1'b0;
        do_start();
        for (int k = 0; k < 4; k++)
            send(7, k, 2, 0, 16'h00F0 + k, 0, k == 3, 0, encode(7, k, 2, 0, 16'h00F0 + k, 0));
        chk("edge_count", 32'(o_count), 4);
        tick();
        chk("edge_idle_err", 32'(o_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
